dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port data memory of Pipe_CPU_1 between two requesters:
//   - the MEM-stage load/store port (CPU);
//   - a debug/loader port that preloads and dumps memory without hierarchical access.
// - Sequences each access through a fixed-latency memory and raises a stall to the pipeline while the CPU waits.
// - Guarantees the debug port is not starved.
// PARAMETERS
// - ADDR_W      32  byte-address width.
// - DATA_W      32  data word width.
// - MEM_LAT     1   memory read latency in cycles, measured from the mem_en_o cycle to mem_rdata_i valid. Legal range 1..15.
// - STARVE_MAX  4   max consecutive CPU grants while dbg_req_i is pending. Legal range 1..15.
// PORTS
// - clk_i        in   1       clock, rising edge.
// - rst_i        in   1       reset, asynchronous, active-low.
// - cpu_req_i    in   1       CPU access request; hold until cpu_ack_o.
// - cpu_we_i     in   1       1 = store, 0 = load.
// - cpu_addr_i   in   ADDR_W  CPU address.
// - cpu_wdata_i  in   DATA_W  CPU store data.
// - cpu_ack_o    out  1       one-cycle completion pulse.
// - cpu_rdata_o  out  DATA_W  load data; valid while cpu_ack_o=1.
// - cpu_stall_o  out  1       cpu_req_i & ~cpu_ack_o (combinational).
// - dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ack_o, dbg_rdata_o: same as the cpu_* ports, for the debug port.
// - mem_en_o     out  1       memory access strobe, one cycle per access.
// - mem_we_o     out  1       write enable; asserted only together with mem_en_o.
// - mem_addr_o   out  ADDR_W  latched address of the granted requester.
// - mem_wdata_o  out  DATA_W  latched write data.
// - mem_rdata_i  in   DATA_W  memory read data.
// - busy_o       out  1       1 whenever state != IDLE.
// BEHAVIOUR
// - Reset (rst_i=0, any time):
//   - state -> IDLE, starve_cnt -> 0.
//   - All outputs 0, including rdata, mem_addr_o and mem_wdata_o.
//   - An in-flight access is abandoned and no ack is issued.
// - FSM, states IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   - IDLE: arbitrate when any request is high. Latch grant, we, addr and wdata, then go to ISSUE. With no request, stay in IDLE.
//   - ISSUE: mem_en_o=1 and mem_we_o=latched we for exactly this cycle. Load the latency counter with MEM_LAT-1 and go to WAIT.
//   - WAIT: count down. When the counter reaches 0 (mem_rdata_i is valid this cycle), capture it on a load and go to RESP.
//   - RESP: the ack of the granted port is 1 for exactly one cycle. Its rdata equals the captured word on a load; on a store, rdata holds its previous value. Unconditionally go to IDLE; requests are not sampled in RESP.
// - Latency:
//   - Request first seen in IDLE at cycle 0: mem_en_o in cycle 1, data valid in cycle MEM_LAT+1, ack in cycle MEM_LAT+2.
//   - Throughput is one access per MEM_LAT+3 cycles.
// - Arbitration (IDLE only):
//   - Only CPU requesting: grant CPU. Only debug requesting: grant debug.
//   - Both requesting: CPU wins unless starve_cnt == STARVE_MAX, in which case debug wins.
//   - starve_cnt increments on each CPU grant while dbg_req_i=1, saturating at STARVE_MAX.
//   - starve_cnt clears on a debug grant or when dbg_req_i=0 in IDLE.
// - Handshake:
//   - A requester must hold req and payload stable from assertion until its ack.
//   - The arbiter uses the latched payload, so mid-access changes have no effect.
//   - Withdrawing req before grant is legal. Withdrawing after grant is illegal; the access still completes and acks.
//   - A requester deasserts req at the ack edge. Req still high in the following IDLE cycle is a new request.
// - Ack rules:
//   - The non-granted port's ack is never asserted.
//   - cpu_ack_o and dbg_ack_o are never high together.
// - Address bits are passed through unchanged; no alignment check is made.
// TESTING
// - MEM_LAT=1, CPU load from 0x10 (memory holds 0xDEADBEEF), req at cycle 0 -> mem_en_o in cycle 1, cpu_ack_o=1 with cpu_rdata_o=0xDEADBEEF in cycle 3, cpu_stall_o=1 in cycles 0-2.
// - CPU store 0x0000002A to 0x4, then a debug load from 0x4 -> dbg_rdata_o=0x2A; dbg_rdata_o unchanged during the store ack.
// - Both ports requesting continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DBG,CPU...; the two acks are never high together.
// - MEM_LAT=3 -> ack exactly 5 cycles after req; mem_en_o is a single-cycle pulse; the data is sampled in the cycle before RESP.
// - rst_i pulled low during WAIT -> all outputs 0 immediately; after release, no stale ack; a fresh request completes normally.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data memory
// arbiter. slave = arbiter side, master = requesters plus memory.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              dbg_stall_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_ack_o, cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_ack_o, dbg_rdata_o, dbg_stall_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_ack_o, cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_ack_o, dbg_rdata_o, dbg_stall_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares a fixed-latency single-port data memory between the CPU MEM
// stage and a debug/loader port; clk_i, async active-low rst_i, bus.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic              gnt_dbg;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic [3:0]        lat_cnt;
  logic [3:0]        starve_cnt;

  logic any_req;
  logic starved;
  logic pick_dbg;
  logic lat_done;
  logic cpu_ack;
  logic dbg_ack;

  assign any_req  = bus.cpu_req_i | bus.dbg_req_i;
  assign starved  = starve_cnt == 4'(STARVE_MAX);
  assign pick_dbg = bus.dbg_req_i
                  & (~bus.cpu_req_i | starved);
  assign lat_done = lat_cnt == 4'd0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (lat_done) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_dbg    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        // Only a CPU win over a waiting debug request counts;
        // it never fires once saturated, so no explicit clamp.
        if (bus.dbg_req_i & ~pick_dbg)
          starve_cnt <= starve_cnt + 4'd1;
        else
          starve_cnt <= '0;
        if (any_req) begin
          gnt_dbg <= pick_dbg;
          if (pick_dbg) begin
            we_q    <= bus.dbg_we_i;
            addr_q  <= bus.dbg_addr_i;
            wdata_q <= bus.dbg_wdata_i;
          end else begin
            we_q    <= bus.cpu_we_i;
            addr_q  <= bus.cpu_addr_i;
            wdata_q <= bus.cpu_wdata_i;
          end
        end
      end
      if (state == ISSUE)
        lat_cnt <= 4'(MEM_LAT - 1);
      else if (state == WAIT && !lat_done)
        lat_cnt <= lat_cnt - 4'd1;
      if (state == WAIT && lat_done && !we_q) begin
        if (gnt_dbg) dbg_rdata <= bus.mem_rdata_i;
        else         cpu_rdata <= bus.mem_rdata_i;
      end
    end
  end

  assign cpu_ack = (state == RESP) & ~gnt_dbg;
  assign dbg_ack = (state == RESP) &  gnt_dbg;

  assign bus.cpu_ack_o   = cpu_ack;
  assign bus.dbg_ack_o   = dbg_ack;
  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.dbg_rdata_o = dbg_rdata;
  // Gated by reset so every output reads 0 while rst_i is low.
  assign bus.cpu_stall_o = rst_i & bus.cpu_req_i & ~cpu_ack;
  assign bus.dbg_stall_o = rst_i & bus.dbg_req_i & ~dbg_ack;

  assign bus.mem_en_o    = state == ISSUE;
  assign bus.mem_we_o    = (state == ISSUE) & we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.busy_o      = state != IDLE;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed cases plus random traffic
// against a transaction-timing model of both ports and the memory.
module tb_dmem_port_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  logic [31:0] mem [64];

  typedef struct {
    bit          who;
    int          cyc;
    logic [31:0] rd;
    logic [31:0] oth;
  } ack_t;
  ack_t acks[$];
  int en_cyc = -1;
  int stall_cnt = 0;

  // Model: an access granted in IDLE cycle g strobes memory at g+1,
  // sees data at g+1+LAT and acks at g+2+LAT.
  bit          m_act = 0;
  int          m_g = 0;
  bit          m_who = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_rdval = 0;
  logic [31:0] lat_addr = 0;
  logic [31:0] lat_wdata = 0;
  logic [31:0] exp_rd [2];
  int          run = 0;
  bit [1:0]    ack_prev = 0;
  int          pend_due = -1;
  logic [31:0] pend_data = 0;

  always @(negedge clk) begin : mdl
    bit       e_busy, e_en, e_we;
    bit [1:0] e_ack;
    int       k;
    if (!rst_n) begin
      m_act = 0; run = 0; ack_prev = 0;
      lat_addr = 0; lat_wdata = 0; pend_due = -1;
      exp_rd[0] = 0; exp_rd[1] = 0;
      chk("rst_ctl", {26'd0, bus.busy_o, bus.mem_en_o,
          bus.mem_we_o, bus.cpu_ack_o, bus.dbg_ack_o,
          bus.cpu_stall_o | bus.dbg_stall_o}, 0);
      chk("rst_addr", bus.mem_addr_o, 0);
      chk("rst_wdata", bus.mem_wdata_o, 0);
      chk("rst_crd", bus.cpu_rdata_o, 0);
      chk("rst_drd", bus.dbg_rdata_o, 0);
    end else begin
      e_busy = 0; e_en = 0; e_we = 0; e_ack = 0; k = 0;
      if (m_act) begin
        k = cyc - m_g;
        e_busy = 1;
        e_en = (k == 1);
        e_we = e_en & m_we;
        if (k == LAT + 2) e_ack[m_who] = 1'b1;
      end
      chk("busy", 32'(bus.busy_o), 32'(e_busy));
      chk("mem_en", 32'(bus.mem_en_o), 32'(e_en));
      chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
      chk("mem_addr", bus.mem_addr_o, lat_addr);
      chk("mem_wdata", bus.mem_wdata_o, lat_wdata);
      chk("cpu_ack", 32'(bus.cpu_ack_o), 32'(e_ack[0]));
      chk("dbg_ack", 32'(bus.dbg_ack_o), 32'(e_ack[1]));
      chk("ack_excl", 32'(bus.cpu_ack_o & bus.dbg_ack_o), 0);
      chk("cpu_rdata", bus.cpu_rdata_o, exp_rd[0]);
      chk("dbg_rdata", bus.dbg_rdata_o, exp_rd[1]);
      chk("cpu_stall", 32'(bus.cpu_stall_o),
          32'(bus.cpu_req_i & ~e_ack[0]));
      chk("dbg_stall", 32'(bus.dbg_stall_o),
          32'(bus.dbg_req_i & ~e_ack[1]));
      ack_prev = e_ack;

      if (bus.cpu_ack_o)
        acks.push_back('{0, cyc, bus.cpu_rdata_o, bus.dbg_rdata_o});
      if (bus.dbg_ack_o)
        acks.push_back('{1, cyc, bus.dbg_rdata_o, bus.cpu_rdata_o});
      if (bus.cpu_stall_o) stall_cnt++;

      if (m_act) begin
        if (k == 1 && !m_we) m_rdval = mem[m_addr[7:2]];
        if (k == LAT + 1 && !m_we) exp_rd[m_who] = m_rdval;
        if (k == LAT + 2) m_act = 0;
      end else if (bus.cpu_req_i | bus.dbg_req_i) begin
        m_who = bus.dbg_req_i & (!bus.cpu_req_i || run == SMAX);
        if (!bus.dbg_req_i || m_who) run = 0;
        else run++;
        m_we   = m_who ? bus.dbg_we_i   : bus.cpu_we_i;
        m_addr = m_who ? bus.dbg_addr_i : bus.cpu_addr_i;
        lat_addr  = m_addr;
        lat_wdata = m_who ? bus.dbg_wdata_i : bus.cpu_wdata_i;
        m_act = 1;
        m_g = cyc;
      end else begin
        run = 0;
      end

      // Memory: writes land on the strobe, reads appear LAT cycles later.
      if (bus.mem_en_o) begin
        en_cyc = cyc;
        if (bus.mem_we_o) begin
          mem[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
        end else begin
          pend_due  = cyc + LAT;
          pend_data = mem[bus.mem_addr_o[7:2]];
        end
      end
    end
    bus.mem_rdata_i = (rst_n && cyc == pend_due) ? pend_data : $urandom;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_go(bit we, logic [31:0] a, logic [31:0] d);
    bus.cpu_req_i = 1; bus.cpu_we_i = we;
    bus.cpu_addr_i = a; bus.cpu_wdata_i = d;
  endtask

  task automatic dbg_go(bit we, logic [31:0] a, logic [31:0] d);
    bus.dbg_req_i = 1; bus.dbg_we_i = we;
    bus.dbg_addr_i = a; bus.dbg_wdata_i = d;
  endtask

  task automatic wait_ack(bit who, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack_prev[who]) begin
        ok = 1;
        break;
      end
    end
    chk("ack_timeout", 32'(ok), 1);
  endtask

  initial begin
    bit ok;
    int c0, s0, n0;
    bit [5:0] order;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    bus.cpu_req_i = 0; bus.cpu_we_i = 0;
    bus.cpu_addr_i = 0; bus.cpu_wdata_i = 0;
    bus.dbg_req_i = 0; bus.dbg_we_i = 0;
    bus.dbg_addr_i = 0; bus.dbg_wdata_i = 0;
    bus.mem_rdata_i = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // CPU load of 0x10: strobe 1 cycle, ack 5 cycles after request.
    c0 = cyc; s0 = stall_cnt;
    cpu_go(0, 32'h10, 32'h0);
    wait_ack(0, ok);
    bus.cpu_req_i = 0;
    chk("a_en_lat", 32'(en_cyc - c0), 1);
    if (ok) begin
      chk("a_ack_lat", 32'(acks[$].cyc - c0), 5);
      chk("a_rdata", acks[$].rd, 32'hDEADBEEF);
    end
    chk("a_stall_cyc", 32'(stall_cnt - s0), 5);
    tick();

    // CPU store then debug load of the same word.
    cpu_go(1, 32'h4, 32'h2A);
    wait_ack(0, ok);
    bus.cpu_req_i = 0;
    if (ok) chk("b_dbg_hold", acks[$].oth, 32'h0);
    dbg_go(0, 32'h4, 32'h0);
    wait_ack(1, ok);
    bus.dbg_req_i = 0;
    if (ok) chk("b_dbg_rd", acks[$].rd, 32'h2A);
    tick();

    // Both ports requesting back to back.
    n0 = acks.size();
    cpu_go(0, 32'h20, 0);
    dbg_go(0, 32'h24, 0);
    for (int i = 0; i < 200 && acks.size() < n0 + 6; i++) begin
      tick();
      if (ack_prev[0]) cpu_go(0, 32'($urandom_range(0, 255)), 0);
      if (ack_prev[1]) dbg_go(0, 32'($urandom_range(0, 255)), 0);
    end
    bus.cpu_req_i = 0; bus.dbg_req_i = 0;
    order = 0;
    for (int i = 0; i < 6; i++)
      if (n0 + i < acks.size()) order[i] = acks[n0 + i].who;
    chk("c_n_acks", 32'(acks.size() - n0 >= 6), 1);
    chk("c_order", 32'(order), 32'b010000);
    repeat (8) tick();

    // Reset while waiting on memory.
    cpu_go(0, 32'h30, 0);
    tick(); tick();
    rst_n = 0;
    bus.cpu_req_i = 0;
    #1;
    chk("d_busy", 32'(bus.busy_o), 0);
    chk("d_addr", bus.mem_addr_o, 0);
    chk("d_crd", bus.cpu_rdata_o, 0);
    chk("d_ack", 32'(bus.cpu_ack_o | bus.dbg_ack_o), 0);
    repeat (2) tick();
    rst_n = 1;
    n0 = acks.size();
    repeat (8) tick();
    chk("d_no_stale", 32'(acks.size() - n0), 0);
    c0 = cyc;
    cpu_go(0, 32'h10, 0);
    wait_ack(0, ok);
    bus.cpu_req_i = 0;
    if (ok) begin
      chk("d_ack_lat", 32'(acks[$].cyc - c0), 5);
      chk("d_rdata", acks[$].rd, 32'hDEADBEEF);
    end

    // Random traffic with legal withdrawals before grant.
    repeat (3000) begin
      tick();
      if (ack_prev[0]) bus.cpu_req_i = 0;
      if (ack_prev[1]) bus.dbg_req_i = 0;
      if (!bus.cpu_req_i) begin
        if ($urandom_range(0, 2) == 0)
          cpu_go(1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)), $urandom);
      end else if (!(m_act && m_who == 0)
                   && $urandom_range(0, 19) == 0) begin
        bus.cpu_req_i = 0;
      end
      if (!bus.dbg_req_i) begin
        if ($urandom_range(0, 3) == 0)
          dbg_go(1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)), $urandom);
      end else if (!(m_act && m_who == 1)
                   && $urandom_range(0, 19) == 0) begin
        bus.dbg_req_i = 0;
      end
    end
    bus.cpu_req_i = 0; bus.dbg_req_i = 0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
